// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: widths, write-back select encoding,
// MEM-stage FSM states and the EX/MEM and MEM/WB register layouts.
package mips_defs;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     rt_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  w_mem_ena;
    logic                  w_reg_ena;
    logic                  wb_sel;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  w_reg_ena;
    logic                  wb_sel;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     rdata;
  } mem_wb_t;

endpackage

// File: rtl/pipe_reg.sv
// Pipeline register: async reset, synchronous clear (priority) and load enable.
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM and MEM/WB registers, req/ack data-memory port
// with wait-cycle timeout, alignment check and front-end stall.
module mem_stage
  import mips_defs::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     ex_alu_res,
  input  logic [DATA_W-1:0]     ex_rt_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_w_mem_ena,
  input  logic                  ex_w_reg_ena,
  input  logic                  ex_wb_sel,
  input  logic                  flush,
  output logic                  mem_stall,
  output logic [DATA_W-1:0]     ex_mem_alu_res,
  output logic [REG_ADDR_W-1:0] ex_mem_rd,
  output logic                  ex_mem_w_reg_ena,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [DATA_W-1:0]     dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_ack,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic [REG_ADDR_W-1:0] mem_wb_rd,
  output logic                  mem_wb_w_reg_ena,
  output logic [DATA_W-1:0]     wb_w_data,
  output logic                  bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  ex_mem_t    ex_mem_d, ex_mem_q;
  mem_wb_t    mem_wb_d, mem_wb_q;
  mem_state_e state_d, state_q;
  logic [7:0] cnt_d, cnt_q;
  logic       bus_err_d, bus_err_q;

  logic store, load, mem_op, aligned, wb_bubble;

  always_comb begin
    store     = ex_mem_q.w_mem_ena;
    load      = (ex_mem_q.wb_sel == WB_SEL_MEM) & ex_mem_q.w_reg_ena & ~ex_mem_q.w_mem_ena;
    mem_op    = store | load;
    aligned   = (ex_mem_q.alu_res[1:0] == 2'b00);
    // dm_req is purely combinational from flops, so it drops with async reset
    dm_req    = mem_op & aligned & (state_q != S_ABORT);
    mem_stall = dm_req & ~dm_ack;
    bus_err_d = (mem_op & ~aligned) | (state_q == S_ABORT);
    wb_bubble = mem_stall | bus_err_d;
  end

  always_comb begin
    ex_mem_d.alu_res   = ex_alu_res;
    ex_mem_d.rt_data   = ex_rt_data;
    ex_mem_d.rd        = ex_rd;
    ex_mem_d.w_mem_ena = ex_w_mem_ena;
    ex_mem_d.w_reg_ena = ex_w_reg_ena;
    ex_mem_d.wb_sel    = ex_wb_sel;

    mem_wb_d.rd        = ex_mem_q.rd;
    mem_wb_d.w_reg_ena = ex_mem_q.w_reg_ena & ~(ex_mem_q.w_mem_ena & ex_mem_q.wb_sel);
    mem_wb_d.wb_sel    = ex_mem_q.wb_sel;
    mem_wb_d.alu_res   = ex_mem_q.alu_res;
    mem_wb_d.rdata     = load ? dm_rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (dm_req && !dm_ack) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (dm_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = S_ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Flush only takes effect on edges where EX/MEM actually advances
  pipe_reg #(.W($bits(ex_mem_t))) u_ex_mem (
    .clk (clk),
    .rst (rst),
    .en  (~mem_stall),
    .clr (flush & ~mem_stall),
    .d   (ex_mem_d),
    .q   (ex_mem_q)
  );

  pipe_reg #(.W($bits(mem_wb_t))) u_mem_wb (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (wb_bubble),
    .d   (mem_wb_d),
    .q   (mem_wb_q)
  );

  assign dm_we            = store;
  assign dm_addr          = ex_mem_q.alu_res;
  assign dm_wdata         = ex_mem_q.rt_data;
  assign ex_mem_alu_res   = ex_mem_q.alu_res;
  assign ex_mem_rd        = ex_mem_q.rd;
  assign ex_mem_w_reg_ena = ex_mem_q.w_reg_ena;
  assign mem_wb_rd        = mem_wb_q.rd;
  assign mem_wb_w_reg_ena = mem_wb_q.w_reg_ena;
  assign wb_w_data        = (mem_wb_q.wb_sel == WB_SEL_ALU) ? mem_wb_q.alu_res : mem_wb_q.rdata;
  assign bus_err          = bus_err_q;

endmodule
